// File: rtl/multi_axis_fir_engine.sv
// Multi-channel FIR engine: one shared signed MAC walks every channel's taps per frame.
// Optional build macro FIR_SAT_EN saturates each result; otherwise results wrap to DATA_W bits.
module multi_axis_fir_engine #(
    parameter int CH     = 3,
    parameter int TAPS   = 16,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NBANK  = 4,
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int TW    = $clog2(TAPS)
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*BW-1:0]     bank_sel,
    input  logic                 upd_en,
    input  logic [CHW-1:0]       upd_ch,
    input  logic [BW-1:0]        upd_bank,
    input  logic [TW-1:0]        upd_idx,
    input  logic [COEF_W-1:0]    upd_value,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 irq
);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = DATA_W + COEF_W + TW;
    localparam logic [TW-1:0]   TAP_LAST = TW'(TAPS - 1);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(CH - 1);
    localparam logic [CHW:0]    CH_LIM   = (CHW + 1)'(CH);
    localparam logic [COEF_W-1:0] COEF_ONE = {1'b0, {(COEF_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t state, state_next;

    logic signed [DATA_W-1:0] dline [CH][TAPS];
    logic signed [COEF_W-1:0] coef  [CH][NBANK][TAPS];
    logic [BW-1:0]            bank_lat [CH];
    logic signed [ACC_W-1:0]  acc, acc_sum;
    logic [CHW-1:0]           ch_idx;
    logic [TW-1:0]            tap_idx;
    logic signed [DATA_W-1:0] smp;
    logic signed [COEF_W-1:0] cf;
    logic signed [PW-1:0]     prod;
    logic [DATA_W-1:0]        res;
    logic                     accept, mac_last;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mac_last   = 1'b0;
        case (state)
            IDLE: if (in_valid && in_ready) begin
                accept     = 1'b1;
                state_next = MAC;
            end
            MAC: if (tap_idx == TAP_LAST && ch_idx == CH_LAST) begin
                mac_last   = 1'b1;
                state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Each channel's sum restarts at its tap 0, so acc only ever holds one channel.
    always_comb begin
        smp     = dline[ch_idx][tap_idx];
        cf      = coef[ch_idx][bank_lat[ch_idx]][tap_idx];
        prod    = $signed({{COEF_W{smp[DATA_W-1]}}, smp}) * $signed({{DATA_W{cf[COEF_W-1]}}, cf});
        acc_sum = ((tap_idx == '0) ? '0 : acc) + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] shifted;
    always_comb begin
        shifted = acc_sum >>> (COEF_W - 1);
        if (shifted > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
        else                        res = shifted[DATA_W-1:0];
    end
`else
    always_comb res = acc_sum[COEF_W-1 +: DATA_W];
`endif

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            irq       <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            ch_idx    <= '0;
            tap_idx   <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                bank_lat[c] <= '0;
                for (int unsigned t = 0; t < TAPS; t++) dline[c][t] <= '0;
                for (int unsigned b = 0; b < NBANK; b++)
                    for (int unsigned t = 0; t < TAPS; t++)
                        coef[c][b][t] <= (b == 0 && t == 0) ? COEF_ONE : '0;
            end
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            irq       <= mac_last;
            if (upd_en && {1'b0, upd_ch} < CH_LIM)
                coef[upd_ch][upd_bank][upd_idx] <= upd_value;
            if (accept) begin
                for (int unsigned c = 0; c < CH; c++) begin
                    dline[c][0] <= in_data[c*DATA_W +: DATA_W];
                    for (int unsigned t = 1; t < TAPS; t++) dline[c][t] <= dline[c][t-1];
                    bank_lat[c] <= bank_sel[c*BW +: BW];
                end
                acc     <= '0;
                ch_idx  <= '0;
                tap_idx <= '0;
            end else if (state == MAC) begin
                acc     <= acc_sum;
                tap_idx <= tap_idx + 1'b1;
                if (tap_idx == TAP_LAST) begin
                    ch_idx <= ch_idx + 1'b1;
                    out_data[ch_idx*DATA_W +: DATA_W] <= res;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_axis_fir_engine.sv
// Directed bench for multi_axis_fir_engine at default parameters (3 ch, 16 taps, 4 banks).
module tb_multi_axis_fir_engine;
    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [47:0] in_data;
    logic        in_valid, in_ready;
    logic [5:0]  bank_sel;
    logic        upd_en;
    logic [1:0]  upd_ch, upd_bank;
    logic [3:0]  upd_idx;
    logic [15:0] upd_value;
    logic [47:0] out_data;
    logic        out_valid, out_ready, irq;

    int nvec = 0;
    int nerr = 0;

`ifdef FIR_SAT_EN
    localparam logic [15:0] WRAP_EXP = 16'h7FFF;
`else
    localparam logic [15:0] WRAP_EXP = 16'hFFFC;
`endif

    multi_axis_fir_engine #(.CH(3), .TAPS(16), .DATA_W(16), .COEF_W(16), .NBANK(4)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bank_sel(bank_sel), .upd_en(upd_en), .upd_ch(upd_ch),
        .upd_bank(upd_bank), .upd_idx(upd_idx), .upd_value(upd_value), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; upd_en = 1'b0; bank_sel = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wcoef(input logic [1:0] ch, input logic [1:0] bank, input logic [3:0] idx,
                         input logic [15:0] val);
        upd_en = 1'b1; upd_ch = ch; upd_bank = bank; upd_idx = idx; upd_value = val;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                             input logic [5:0] bsel, input logic [5:0] bsel_after,
                             output logic [47:0] res, output int lat, output int irqs);
        int w;
        irqs = 0; lat = -1; res = 'x;
        in_data = {d2, d1, d0}; bank_sel = bsel; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        if (!in_ready) begin in_valid = 1'b0; return; end
        tick();
        in_valid = 1'b0; bank_sel = bsel_after;
        lat = 0;
        while (!out_valid && lat < 200) begin tick(); lat++; irqs += int'(irq); end
        res = out_data;
        out_ready = 1'b1;
        tick();
        irqs += int'(irq);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; upd_en = 1'b0; bank_sel = '0;
        in_data = {16'd0, 16'd0, 16'd1000};
        tick(); tick();
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL rst_irq: got %b want 0", irq); end
        nvec++; if (out_data !== 48'd0) begin nerr++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        reset_n = 1'b1;
        tick();
        in_valid = 1'b0;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_impulse();
        logic [47:0] r; int lat, irqs;
        do_reset();
        run_frame(16'd1000, 16'd0, 16'hFC18, 6'd0, 6'd0, r, lat, irqs);
        nvec++; if (lat !== 48) begin nerr++; $display("FAIL imp_latency: got %0d want 48", lat); end
        nvec++; if (r[15:0] !== 16'd999) begin nerr++; $display("FAIL imp_ch0: got %h want %h", r[15:0], 16'd999); end
        nvec++; if (r[31:16] !== 16'd0) begin nerr++; $display("FAIL imp_ch1: got %h want 0", r[31:16]); end
        nvec++; if (r[47:32] !== 16'hFC18) begin nerr++; $display("FAIL imp_ch2: got %h want fc18", r[47:32]); end
        nvec++; if (irqs !== 1) begin nerr++; $display("FAIL imp_irq_count: got %0d want 1", irqs); end
    endtask

    task automatic test_banks();
        logic [47:0] r; int lat, irqs;
        logic [15:0] want;
        do_reset();
        for (int t = 0; t < 4; t++) wcoef(2'd1, 2'd1, 4'(t), 16'h2000);
        for (int k = 1; k <= 4; k++) begin
            // the last frame drops bank_sel back to 0 right after acceptance
            run_frame(16'd0, 16'd4000, 16'd0, 6'b00_01_00, (k == 4) ? 6'd0 : 6'b00_01_00, r, lat, irqs);
            want = 16'(1000 * k);
            nvec++; if (r[31:16] !== want) begin nerr++; $display("FAIL bank_ch1_f%0d: got %0d want %0d", k, r[31:16], want); end
        end
        nvec++; if ({r[47:32], r[15:0]} !== 32'd0) begin nerr++; $display("FAIL bank_others: got %h want 0", {r[47:32], r[15:0]}); end
    endtask

    task automatic test_wrap();
        logic [47:0] r; int lat, irqs;
        do_reset();
        wcoef(2'd2, 2'd0, 4'd1, 16'h7FFF);
        run_frame(16'd0, 16'd0, 16'h7FFF, 6'd0, 6'd0, r, lat, irqs);
        nvec++; if (r[47:32] !== 16'h7FFE) begin nerr++; $display("FAIL wrap_first: got %h want 7ffe", r[47:32]); end
        run_frame(16'd0, 16'd0, 16'h7FFF, 6'd0, 6'd0, r, lat, irqs);
        nvec++; if (r[47:32] !== WRAP_EXP) begin nerr++; $display("FAIL wrap_second: got %h want %h", r[47:32], WRAP_EXP); end
    endtask

    task automatic test_backpressure();
        logic [47:0] snap; int w, lat, irqs, bad_stable, bad_ready, nov;
        do_reset();
        in_data = {16'd0, 16'd0, 16'd1000}; bank_sel = '0; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        tick();
        lat = 0;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        nvec++; if (lat !== 48) begin nerr++; $display("FAIL bp_latency: got %0d want 48", lat); end
        in_data = {16'd0, 16'd0, 16'd500};
        snap = out_data; irqs = int'(irq); bad_stable = 0; bad_ready = 0;
        repeat (10) begin
            tick();
            irqs += int'(irq);
            if (out_data !== snap || out_valid !== 1'b1) bad_stable++;
            if (in_ready !== 1'b0) bad_ready++;
        end
        nvec++; if (snap[15:0] !== 16'd999) begin nerr++; $display("FAIL bp_ch0: got %0d want 999", snap[15:0]); end
        nvec++; if (bad_stable !== 0) begin nerr++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_stable); end
        nvec++; if (bad_ready !== 0) begin nerr++; $display("FAIL bp_in_ready: got %0d ready cycles want 0", bad_ready); end
        nvec++; if (irqs !== 1) begin nerr++; $display("FAIL bp_irq_count: got %0d want 1", irqs); end
        out_ready = 1'b1;
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_release: got %b want 0", out_valid); end
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick(); lat++;
            if (lat == 1) in_valid = 1'b0;
        end
        nvec++; if (lat !== 49) begin nerr++; $display("FAIL bp_next_latency: got %0d want 49", lat); end
        nvec++; if (out_data[15:0] !== 16'd499) begin nerr++; $display("FAIL bp_next_ch0: got %0d want 499", out_data[15:0]); end
        nov = 0;
        repeat (60) begin tick(); nov += int'(out_valid); end
        nvec++; if (nov !== 0) begin nerr++; $display("FAIL bp_no_dup: got %0d valid cycles want 0", nov); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [47:0] r; int w, lat, irqs, nov, nirq;
        do_reset();
        in_data = {16'hFC18, 16'd0, 16'd1000}; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        reset_n = 1'b0;
        tick();
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        reset_n = 1'b1;
        nov = 0; nirq = 0;
        repeat (60) begin tick(); nov += int'(out_valid); nirq += int'(irq); end
        nvec++; if (nov !== 0) begin nerr++; $display("FAIL mid_rst_valid: got %0d want 0", nov); end
        nvec++; if (nirq !== 0) begin nerr++; $display("FAIL mid_rst_irq: got %0d want 0", nirq); end
        run_frame(16'd1000, 16'd0, 16'hFC18, 6'd0, 6'd0, r, lat, irqs);
        nvec++; if (r !== {16'hFC18, 16'd0, 16'd999}) begin nerr++; $display("FAIL mid_rst_result: got %h want fc1800000003e7", r); end
    endtask

    task automatic test_bad_ch();
        logic [47:0] r; int lat, irqs;
        do_reset();
        wcoef(2'd3, 2'd0, 4'd0, 16'h1234);
        wcoef(2'd3, 2'd0, 4'd1, 16'h1234);
        run_frame(16'd1000, 16'd1000, 16'hFC18, 6'd0, 6'd0, r, lat, irqs);
        nvec++; if (r !== {16'hFC18, 16'd999, 16'd999}) begin nerr++; $display("FAIL bad_ch_result: got %h want fc1803e703e7", r); end
    endtask

    task automatic test_same_edge();
        logic [47:0] r; int w, lat, irqs;
        do_reset();
        in_data = {16'd0, 16'd0, 16'd1000}; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        tick();
        in_valid = 1'b0;
        // this write lands on the very edge that reads ch0 bank0 tap0
        upd_en = 1'b1; upd_ch = 2'd0; upd_bank = 2'd0; upd_idx = 4'd0; upd_value = 16'd0;
        tick();
        upd_en = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        nvec++; if (lat !== 48) begin nerr++; $display("FAIL same_edge_latency: got %0d want 48", lat); end
        nvec++; if (out_data[15:0] !== 16'd999) begin nerr++; $display("FAIL same_edge_old: got %0d want 999", out_data[15:0]); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        run_frame(16'd1000, 16'd0, 16'd0, 6'd0, 6'd0, r, lat, irqs);
        nvec++; if (r[15:0] !== 16'd0) begin nerr++; $display("FAIL same_edge_new: got %0d want 0", r[15:0]); end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; upd_en = 1'b0;
        upd_ch = '0; upd_bank = '0; upd_idx = '0; upd_value = '0; bank_sel = '0; in_data = '0;
        test_reset();
        test_impulse();
        test_banks();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_bad_ch();
        test_same_edge();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
